// File: rtl/pr_queue_reader_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pr_queue_reader_if                                                 |
// | AXI-lite read channels toward the request queue plus the           |
// | downstream popped-request handshake.                               |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
interface pr_queue_reader_if;
   logic [3:0]  m_axi_araddr;
   logic        m_axi_arvalid;
   logic        m_axi_arready;
   logic [31:0] m_axi_rdata;
   logic        m_axi_rvalid;
   logic        m_axi_rready;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_data;

   // Reader side: drives the read address and the popped request.
   modport master (
      output m_axi_araddr, m_axi_arvalid, m_axi_rready, req_valid, req_data,
      input  m_axi_arready, m_axi_rdata, m_axi_rvalid, req_ready
   );

   // Queue slave and downstream consumer side.
   modport slave (
      input  m_axi_araddr, m_axi_arvalid, m_axi_rready, req_valid, req_data,
      output m_axi_arready, m_axi_rdata, m_axi_rvalid, req_ready
   );
endinterface
`default_nettype wire

// File: rtl/pr_queue_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pr_queue_reader                                                    |
// | Polls a request queue over AXI-lite (CHECK read, then POP read)    |
// | and hands each popped word downstream with a valid/ready handshake.|
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module pr_queue_reader #(
   parameter int unsigned POLL_INTERVAL = 64,
   parameter logic [3:0]  CHECK_ADDR    = 4'hC,
   parameter logic [3:0]  POP_ADDR      = 4'h8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    pr_irq,
   pr_queue_reader_if.master       bus,
   output logic                    busy,
   output logic [15:0]             pop_count
);

   localparam logic [15:0] c_POLL_RELOAD = 16'(POLL_INTERVAL - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CHK_AR  = 3'd1,
      ST_CHK_R   = 3'd2,
      ST_POP_AR  = 3'd3,
      ST_POP_R   = 3'd4,
      ST_DELIVER = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_poll_cnt;
   logic [31:0] r_req_data;
   logic [15:0] r_pop_count;

   logic        w_arvalid;
   logic [3:0]  w_araddr;
   logic        w_rready;
   logic        w_req_valid;

   // State register; reset abandons any read in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and bus outputs; address is zero whenever arvalid is low.
   always_comb begin
      w_state_nxt = r_state;
      w_arvalid   = 1'b0;
      w_araddr    = 4'h0;
      w_rready    = 1'b0;
      w_req_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (enable && (pr_irq || (r_poll_cnt == 16'd0))) begin
               w_state_nxt = ST_CHK_AR;
            end
         end
         ST_CHK_AR: begin
            w_arvalid = 1'b1;
            w_araddr  = CHECK_ADDR;
            if (bus.m_axi_arready) begin
               w_state_nxt = ST_CHK_R;
            end
         end
         ST_CHK_R: begin
            w_rready = 1'b1;
            if (bus.m_axi_rvalid) begin
               // A pending request is only popped while polling is still allowed.
               if ((bus.m_axi_rdata != 32'd0) && enable) begin
                  w_state_nxt = ST_POP_AR;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         ST_POP_AR: begin
            w_arvalid = 1'b1;
            w_araddr  = POP_ADDR;
            if (bus.m_axi_arready) begin
               w_state_nxt = ST_POP_R;
            end
         end
         ST_POP_R: begin
            w_rready = 1'b1;
            if (bus.m_axi_rvalid) begin
               w_state_nxt = ST_DELIVER;
            end
         end
         ST_DELIVER: begin
            w_req_valid = 1'b1;
            if (bus.req_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Poll counter: held at reload outside IDLE so it is fresh on IDLE entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_poll_cnt <= c_POLL_RELOAD;
      end else if (r_state != ST_IDLE) begin
         r_poll_cnt <= c_POLL_RELOAD;
      end else if (enable && (r_poll_cnt != 16'd0)) begin
         r_poll_cnt <= r_poll_cnt - 16'd1;
      end
   end

   // Capture the popped word on the POP read data beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req_data <= 32'd0;
      end else if ((r_state == ST_POP_R) && bus.m_axi_rvalid) begin
         r_req_data <= bus.m_axi_rdata;
      end
   end

   // Count downstream deliveries; wraps naturally at 2^16.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pop_count <= 16'd0;
      end else if ((r_state == ST_DELIVER) && bus.req_ready) begin
         r_pop_count <= r_pop_count + 16'd1;
      end
   end

   assign bus.m_axi_arvalid = w_arvalid;
   assign bus.m_axi_araddr  = w_araddr;
   assign bus.m_axi_rready  = w_rready;
   assign bus.req_valid     = w_req_valid;
   assign bus.req_data      = r_req_data;
   assign busy              = (r_state != ST_IDLE);
   assign pop_count         = r_pop_count;

endmodule
`default_nettype wire

// File: tb/tb_pr_queue_reader.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pr_queue_reader                                                 |
// | Self-checking bench: AXI-lite slave model, monitor and scoreboard. |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tb_pr_queue_reader;
   localparam int P = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        pr_irq;
   logic        busy;
   logic [15:0] pop_count;

   pr_queue_reader_if bus();

   pr_queue_reader #(.POLL_INTERVAL(P), .CHECK_ADDR(4'hC), .POP_ADDR(4'h8)) dut (
      .clk(clk), .rst(rst), .enable(enable), .pr_irq(pr_irq),
      .bus(bus), .busy(busy), .pop_count(pop_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // slave configuration and state
   int          ar_delay = 0;
   int          r_delay = 0;
   logic [31:0] chk_word = 32'd0;
   logic [31:0] pop_word = 32'd0;

   // scoreboard and monitor statistics
   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];
   logic [3:0]  ar_log[$];
   int          ar_cyc[$];
   int ar_hs, r_hs, arvalid_cyc, rready_cyc, req_valid_cyc, proto_err;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // AXI-lite slave model: decisions made 1ns after each rising edge.
   initial begin
      logic       rd_pend, ar_fire;
      logic [3:0] ar_addr_l, rd_addr;
      int         ar_cnt, r_cnt;
      rd_pend = 0; ar_fire = 0; ar_addr_l = 0; rd_addr = 0; ar_cnt = 0; r_cnt = 0;
      bus.m_axi_arready = 0; bus.m_axi_rvalid = 0; bus.m_axi_rdata = 0;
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            rd_pend = 0; ar_fire = 0; ar_cnt = 0; r_cnt = 0;
            bus.m_axi_arready = 0; bus.m_axi_rvalid = 0; bus.m_axi_rdata = 0;
         end else begin
            if (ar_fire) begin
               rd_pend = 1; rd_addr = ar_addr_l; r_cnt = 0; ar_fire = 0;
            end
            if (bus.m_axi_rvalid) begin
               bus.m_axi_rvalid = 0; bus.m_axi_rdata = 0; rd_pend = 0;
            end
            bus.m_axi_arready = 0;
            if (rd_pend && bus.m_axi_rready) begin
               if (r_cnt >= r_delay) begin
                  bus.m_axi_rvalid = 1;
                  if (rd_addr == 4'h8) begin
                     bus.m_axi_rdata = pop_word;
                     exp_q.push_back(pop_word);
                     pop_word = pop_word + 32'd1;
                  end else begin
                     bus.m_axi_rdata = chk_word;
                  end
               end else begin
                  r_cnt++;
               end
            end
            if (bus.m_axi_arvalid && !rd_pend && !ar_fire) begin
               if (ar_cnt >= ar_delay) begin
                  bus.m_axi_arready = 1; ar_fire = 1; ar_addr_l = bus.m_axi_araddr; ar_cnt = 0;
               end else begin
                  ar_cnt++;
               end
            end
         end
      end
   end

   // Monitor on the falling edge: handshakes, stability, delivered words.
   initial begin
      logic       prev_ar_wait, prev_req_wait;
      logic [3:0] prev_araddr;
      logic [31:0] prev_req_data;
      prev_ar_wait = 0; prev_req_wait = 0; prev_araddr = 0; prev_req_data = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_ar_wait = 0; prev_req_wait = 0;
         end else begin
            if (prev_ar_wait && (!bus.m_axi_arvalid || bus.m_axi_araddr != prev_araddr)) proto_err++;
            if (prev_req_wait && (!bus.req_valid || bus.req_data != prev_req_data)) proto_err++;
            if (!bus.m_axi_arvalid && bus.m_axi_araddr != 4'h0) proto_err++;
            if (bus.m_axi_arvalid) arvalid_cyc++;
            if (bus.m_axi_rready) rready_cyc++;
            if (bus.req_valid) req_valid_cyc++;
            if (bus.m_axi_arvalid && bus.m_axi_arready) begin
               ar_hs++; ar_log.push_back(bus.m_axi_araddr); ar_cyc.push_back(cyc);
            end
            if (bus.m_axi_rvalid && bus.m_axi_rready) r_hs++;
            if (bus.req_valid && bus.req_ready) got_q.push_back(bus.req_data);
            prev_ar_wait  = bus.m_axi_arvalid && !bus.m_axi_arready;
            prev_araddr   = bus.m_axi_araddr;
            prev_req_wait = bus.req_valid && !bus.req_ready;
            prev_req_data = bus.req_data;
         end
      end
   end

   task automatic step;
      @(posedge clk); #2;
   endtask

   task automatic clear_stats;
      ar_hs = 0; r_hs = 0; arvalid_cyc = 0; rready_cyc = 0; req_valid_cyc = 0; proto_err = 0;
      ar_log.delete(); ar_cyc.delete(); got_q.delete(); exp_q.delete();
   endtask

   task automatic do_reset;
      step;
      rst = 1; enable = 0; pr_irq = 0; bus.req_ready = 0; ar_delay = 0; r_delay = 0;
      step; step;
      rst = 0;
      clear_stats();
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      checks++; if (bus.m_axi_arvalid !== 1'b0) begin failures++; $display("FAIL reset_arvalid: got %0b expected 0", bus.m_axi_arvalid); end
      checks++; if (bus.m_axi_araddr !== 4'h0) begin failures++; $display("FAIL reset_araddr: got %0h expected 0", bus.m_axi_araddr); end
      checks++; if (bus.m_axi_rready !== 1'b0) begin failures++; $display("FAIL reset_rready: got %0b expected 0", bus.m_axi_rready); end
      checks++; if (bus.req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid: got %0b expected 0", bus.req_valid); end
      checks++; if (bus.req_data !== 32'd0) begin failures++; $display("FAIL reset_req_data: got %0h expected 0", bus.req_data); end
      checks++; if (pop_count !== 16'd0) begin failures++; $display("FAIL reset_pop_count: got %0d expected 0", pop_count); end
   endtask

   task automatic test_poll;
      int t0, n;
      do_reset();
      chk_word = 32'd0;
      enable = 1;
      t0 = cyc;
      n = 0;
      while (ar_log.size() < 4 && n < 200) begin step; n++; end
      checks++;
      if (ar_log.size() < 4) begin
         failures++; $display("FAIL poll_timeout: got %0d reads expected 4", ar_log.size());
      end else begin
         checks++; if (ar_cyc[0] - t0 != P) begin failures++; $display("FAIL poll_first: got %0d cycles expected %0d", ar_cyc[0] - t0, P); end
         for (int i = 1; i < 4; i++) begin
            checks++; if (ar_cyc[i] - ar_cyc[i-1] != P + 2) begin failures++; $display("FAIL poll_interval: got %0d expected %0d", ar_cyc[i] - ar_cyc[i-1], P + 2); end
         end
         for (int i = 0; i < 4; i++) begin
            checks++; if (ar_log[i] !== 4'hC) begin failures++; $display("FAIL poll_addr: got %0h expected c", ar_log[i]); end
         end
      end
      checks++; if (req_valid_cyc != 0) begin failures++; $display("FAIL poll_req_valid: got %0d cycles expected 0", req_valid_cyc); end
      checks++; if (proto_err != 0) begin failures++; $display("FAIL poll_protocol: got %0d errors expected 0", proto_err); end
      enable = 0;
   endtask

   task automatic test_irq_pop;
      int n;
      logic [31:0] g, e;
      do_reset();
      chk_word = 32'hFFFF_FFFF; pop_word = 32'h0000_0123;
      bus.req_ready = 1; enable = 1; pr_irq = 1;
      n = 0;
      while (!bus.req_valid && n < 50) begin step; n++; end
      checks++; if (n != 5) begin failures++; $display("FAIL irq_latency: got %0d expected 5", n); end
      pr_irq = 0; enable = 0;
      repeat (5) step;
      checks++;
      if (got_q.size() != 1 || exp_q.size() != 1) begin
         failures++; $display("FAIL irq_count: got %0d delivered expected 1", got_q.size());
      end else begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         checks++; if (g !== e) begin failures++; $display("FAIL irq_data: got %0h expected %0h", g, e); end
         checks++; if (g !== 32'h123) begin failures++; $display("FAIL irq_data_abs: got %0h expected 123", g); end
      end
      checks++;
      if (ar_log.size() != 2) begin
         failures++; $display("FAIL irq_reads: got %0d expected 2", ar_log.size());
      end else begin
         checks++; if (ar_log[0] !== 4'hC || ar_log[1] !== 4'h8) begin failures++; $display("FAIL irq_addrs: got %0h,%0h expected c,8", ar_log[0], ar_log[1]); end
      end
      checks++; if (req_valid_cyc != 1) begin failures++; $display("FAIL irq_valid_len: got %0d expected 1", req_valid_cyc); end
      checks++; if (pop_count !== 16'd1) begin failures++; $display("FAIL irq_pop_count: got %0d expected 1", pop_count); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL irq_idle: got %0b expected 0", busy); end
   endtask

   task automatic test_delays;
      int n;
      logic [31:0] g, e;
      do_reset();
      ar_delay = 3; r_delay = 4;
      chk_word = 32'h1; pop_word = 32'hABCD_0042;
      bus.req_ready = 1; enable = 1; pr_irq = 1;
      n = 0;
      while (got_q.size() < 1 && n < 100) begin step; n++; end
      pr_irq = 0; enable = 0;
      checks++;
      if (got_q.size() < 1 || exp_q.size() < 1) begin
         failures++; $display("FAIL delay_timeout: got %0d delivered expected 1", got_q.size());
      end else begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         checks++; if (g !== e) begin failures++; $display("FAIL delay_data: got %0h expected %0h", g, e); end
      end
      repeat (3) step;
      checks++; if (ar_hs != 2) begin failures++; $display("FAIL delay_ar_hs: got %0d expected 2", ar_hs); end
      checks++; if (r_hs != 2) begin failures++; $display("FAIL delay_r_hs: got %0d expected 2", r_hs); end
      checks++; if (arvalid_cyc != 8) begin failures++; $display("FAIL delay_arvalid_len: got %0d expected 8", arvalid_cyc); end
      checks++; if (rready_cyc != 10) begin failures++; $display("FAIL delay_rready_len: got %0d expected 10", rready_cyc); end
      checks++; if (proto_err != 0) begin failures++; $display("FAIL delay_protocol: got %0d errors expected 0", proto_err); end
      ar_delay = 0; r_delay = 0;
   endtask

   task automatic test_backpressure;
      int n, bad, hs0;
      logic [31:0] g, e, held;
      do_reset();
      chk_word = 32'h1; pop_word = 32'h5A5A_0007;
      bus.req_ready = 0; enable = 1; pr_irq = 1;
      n = 0;
      while (!bus.req_valid && n < 50) begin step; n++; end
      pr_irq = 0;
      held = (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF;
      hs0 = ar_hs;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!bus.req_valid || bus.req_data !== held) bad++;
         step;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad); end
      checks++; if (ar_hs != hs0) begin failures++; $display("FAIL bp_no_reads: got %0d reads expected %0d", ar_hs, hs0); end
      checks++; if (pop_count !== 16'd0) begin failures++; $display("FAIL bp_count_hold: got %0d expected 0", pop_count); end
      bus.req_ready = 1;
      step; step;
      enable = 0;
      checks++; if (pop_count !== 16'd1) begin failures++; $display("FAIL bp_count: got %0d expected 1", pop_count); end
      checks++; if (bus.req_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_drop: got %0b expected 0", bus.req_valid); end
      checks++;
      if (got_q.size() != 1 || exp_q.size() != 1) begin
         failures++; $display("FAIL bp_deliveries: got %0d expected 1", got_q.size());
      end else begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         checks++; if (g !== e) begin failures++; $display("FAIL bp_data: got %0h expected %0h", g, e); end
      end
      checks++; if (proto_err != 0) begin failures++; $display("FAIL bp_protocol: got %0d errors expected 0", proto_err); end
   endtask

   task automatic test_reset_mid;
      int n;
      logic [31:0] g, e;
      // Starts from the previous scenario's state so req_data/pop_count are nonzero.
      clear_stats();
      r_delay = 6; chk_word = 32'h1; pop_word = 32'h0000_0077;
      bus.req_ready = 1; enable = 1; pr_irq = 1;
      n = 0;
      while (!(bus.m_axi_rready && ar_log.size() == 2) && n < 50) begin step; n++; end
      checks++; if (n >= 50) begin failures++; $display("FAIL rstmid_reach_pop_r: got timeout expected POP_R"); end
      @(negedge clk); #2;
      rst = 1;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %0b expected 0", busy); end
      checks++; if (bus.m_axi_rready !== 1'b0) begin failures++; $display("FAIL rstmid_rready: got %0b expected 0", bus.m_axi_rready); end
      checks++; if (bus.m_axi_arvalid !== 1'b0 || bus.m_axi_araddr !== 4'h0) begin failures++; $display("FAIL rstmid_ar: got %0b/%0h expected 0/0", bus.m_axi_arvalid, bus.m_axi_araddr); end
      checks++; if (bus.req_valid !== 1'b0) begin failures++; $display("FAIL rstmid_req_valid: got %0b expected 0", bus.req_valid); end
      checks++; if (bus.req_data !== 32'd0) begin failures++; $display("FAIL rstmid_req_data: got %0h expected 0", bus.req_data); end
      checks++; if (pop_count !== 16'd0) begin failures++; $display("FAIL rstmid_pop_count: got %0d expected 0", pop_count); end
      pr_irq = 0;
      step; step;
      rst = 0;
      checks++; if (exp_q.size() != 0 || got_q.size() != 0) begin failures++; $display("FAIL rstmid_abandon: got %0d/%0d words expected 0/0", exp_q.size(), got_q.size()); end
      clear_stats();
      r_delay = 0; pr_irq = 1;
      n = 0;
      while (got_q.size() < 1 && n < 50) begin step; n++; end
      pr_irq = 0; enable = 0;
      checks++;
      if (ar_log.size() < 1) begin
         failures++; $display("FAIL rstmid_first_read: got none expected c");
      end else begin
         checks++; if (ar_log[0] !== 4'hC) begin failures++; $display("FAIL rstmid_first_addr: got %0h expected c", ar_log[0]); end
      end
      checks++;
      if (got_q.size() < 1 || exp_q.size() < 1) begin
         failures++; $display("FAIL rstmid_redeliver: got %0d expected 1", got_q.size());
      end else begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         checks++; if (g !== e) begin failures++; $display("FAIL rstmid_data: got %0h expected %0h", g, e); end
      end
   endtask

   task automatic test_enable_drop;
      int n;
      logic [31:0] g, e;
      do_reset();
      r_delay = 3; chk_word = 32'h8000_0000; pop_word = 32'h0000_0099;
      bus.req_ready = 1; enable = 1; pr_irq = 1;
      n = 0;
      while (!bus.m_axi_rready && n < 50) begin step; n++; end
      enable = 0; pr_irq = 0;
      repeat (20) step;
      checks++; if (ar_hs != 1 || r_hs != 1) begin failures++; $display("FAIL endrop_reads: got %0d/%0d expected 1/1", ar_hs, r_hs); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL endrop_idle: got %0b expected 0", busy); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL endrop_no_pop: got %0d pops expected 0", exp_q.size()); end
      enable = 1; pr_irq = 1;
      n = 0;
      while (got_q.size() < 1 && n < 100) begin step; n++; end
      pr_irq = 0; enable = 0;
      checks++;
      if (ar_log.size() != 3) begin
         failures++; $display("FAIL endrop_resume_reads: got %0d expected 3", ar_log.size());
      end else begin
         checks++; if (ar_log[1] !== 4'hC || ar_log[2] !== 4'h8) begin failures++; $display("FAIL endrop_resume_addrs: got %0h,%0h expected c,8", ar_log[1], ar_log[2]); end
      end
      checks++;
      if (got_q.size() < 1 || exp_q.size() < 1) begin
         failures++; $display("FAIL endrop_deliver: got %0d expected 1", got_q.size());
      end else begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         checks++; if (g !== e) begin failures++; $display("FAIL endrop_data: got %0h expected %0h", g, e); end
      end
      r_delay = 0;
   endtask

   initial begin
      rst = 1; enable = 0; pr_irq = 0; bus.req_ready = 0;
      clear_stats();
      test_reset();
      test_poll();
      test_irq_pop();
      test_delays();
      test_backpressure();
      test_reset_mid();
      test_enable_drop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pr_queue_reader.md
PR_QUEUE_READER -- requirements
Module: pr_queue_reader

Interface
REQ-001 Parameter: POLL_INTERVAL, 64, idle cycles between pending checks when no interrupt; legal range 1..65535.
REQ-002 Parameter: CHECK_ADDR, 4'hC, read address returning all-ones if a request is pending, zero otherwise.
REQ-003 Parameter: POP_ADDR, 4'h8, read address returning and removing the oldest request.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  reset; asynchronous and active-high.
REQ-006 enable  input  1  polling permitted while high.
REQ-007 pr_irq  input  1  request-pending level from queue; forces an immediate check.
REQ-008 m_axi_araddr  output  4  read address.
REQ-009 m_axi_arvalid  output  1  read address valid.
REQ-010 m_axi_arready  input  1  read address accepted.
REQ-011 m_axi_rdata  input  32  read data.
REQ-012 m_axi_rvalid  input  1  read data valid.
REQ-013 m_axi_rready  output  1  read data accepted.
REQ-014 req_valid  output  1  popped request available downstream.
REQ-015 req_ready  input  1  downstream accepts request.
REQ-016 req_data  output  32  popped word, {ou_id, grid_slot} in low bits as returned.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 pop_count  output  16  number of requests delivered downstream, wraps at 2^16.

Function
REQ-019 States: IDLE, CHK_AR, CHK_R, POP_AR, POP_R, DELIVER; one transaction outstanding at most.
REQ-020 IDLE: poll counter loads POLL_INTERVAL-1 on entry, decrements each cycle while enable high, holds while enable low.
REQ-021 IDLE -> CHK_AR when enable high and (counter == 0 or pr_irq high); pr_irq wins over counter.
REQ-022 CHK_AR/POP_AR: arvalid high with araddr = CHECK_ADDR/POP_ADDR, address stable until the arvalid&&arready cycle; then -> CHK_R/POP_R next cycle.
REQ-023 arvalid never deasserts before arready; araddr = 0 when arvalid low.
REQ-024 CHK_R/POP_R: rready high for the whole state; data captured in the rvalid&&rready cycle.
REQ-025 CHK_R: rdata != 0 -> POP_AR; rdata == 0 -> IDLE.
REQ-026 POP_R: rdata captured into req_data register -> DELIVER.
REQ-027 DELIVER: req_valid high; req_data stable until req_valid&&req_ready; then pop_count increments, -> IDLE.
REQ-028 Minimum latency pr_irq to req_valid with zero-wait slave: 5 cycles (CHK_AR, CHK_R, POP_AR, POP_R, DELIVER).
REQ-029 enable falling mid-transaction: current AXI read and any delivery complete; return to IDLE; no new read issued until enable high.
REQ-030 rvalid or arready arriving in an unrelated state is ignored; rready low outside CHK_R/POP_R.
REQ-031 A popped word is never dropped or duplicated; exactly one req_valid handshake per POP read.
REQ-032 pop_count 16'hFFFF + 1 -> 16'h0000.

Reset
REQ-033 rst high asynchronously forces IDLE; arvalid, rready, req_valid, busy low; araddr, req_data, pop_count zero; counter = POLL_INTERVAL-1.
REQ-034 rst mid-transaction abandons the read without completing it; after release, the first read issued is a CHECK.

Verification
REQ-035 enable=1, pr_irq=0, slave always returns 0: CHECK reads at araddr 4'hC every POLL_INTERVAL+2 cycles (zero-wait slave), req_valid never high.
REQ-036 pr_irq=1, CHECK returns 32'hFFFFFFFF, POP returns 32'h0000_0123, req_ready=1: araddr 4'hC then 4'h8, req_data=32'h123 for one cycle, pop_count=1.
REQ-037 arready delayed 3 cycles and rvalid delayed 4 cycles: arvalid/araddr stable throughout, exactly one handshake per channel.
REQ-038 req_ready held low 10 cycles in DELIVER: req_valid and req_data stable, no further AXI reads, pop_count increments once on acceptance.
REQ-039 rst pulsed during POP_R wait: all outputs at reset values within the same cycle; after release, first araddr is 4'hC.
REQ-040 enable dropped during CHK_R with CHECK returning nonzero: state returns to IDLE after the read, no POP issued until enable returns.
